// File: rtl/aes_ctrl_pkg.sv
// Shared constants and types for the AES core scheduler.
package aes_ctrl_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY,
        DONE
    } sched_state_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after last_id+1, wrapping.
module aes_rr_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    int              idx;
    logic [ID_W-1:0] sel;

    // Walk candidates from farthest to nearest so the nearest valid one overwrites the rest.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant    = '0;
        grant_id = '0;
        idx      = 0;
        sel      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_id) + k) % NUM_REQ;
            sel = ID_W'(idx);
            if (req_valid[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                grant_id   = sel;
            end
        end
    end

endmodule

// File: rtl/aes_encrypt_sched.sv
// Shares one AES-128 core among NUM_REQ requesters: round-robin grant, start pulse,
// key held during the run, tagged response, watchdog against a hung core.
module aes_encrypt_sched
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0][AES_BLOCK_W-1:0]     req_plain_text,
    input  logic [NUM_REQ-1:0][AES_BLOCK_W-1:0]     req_key,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic [AES_BLOCK_W-1:0]                  core_plain_text,
    output logic [AES_BLOCK_W-1:0]                  core_key,
    output logic                                    core_new_en,
    input  logic                                    core_ready,
    input  logic [AES_BLOCK_W-1:0]                  core_cipher_text,
    output logic                                    rsp_valid,
    input  logic                                    rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]              rsp_id,
    output logic [AES_BLOCK_W-1:0]                  rsp_cipher_text,
    output logic                                    rsp_err,
    output logic                                    busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    sched_state_t        state, state_next;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id, last_id, cur_id;
    logic                seen_low;
    logic [WD_W-1:0]     wdog;
    logic                done_ok, done_tmo;

    aes_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid (req_valid),
        .last_id   (last_id),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here; it is only sampled on the clock edge.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        core_new_en = 1'b0;
        rsp_valid   = 1'b0;
        done_ok     = 1'b0;
        done_tmo    = 1'b0;
        case (state)
            IDLE: if (|req_valid && core_ready) begin
                req_ready  = grant;
                state_next = LOAD;
            end
            LOAD: begin
                core_new_en = 1'b1;
                state_next  = BUSY;
            end
            // A genuine completion in the last watchdog cycle wins over the timeout.
            BUSY: if (seen_low && core_ready) begin
                done_ok    = 1'b1;
                state_next = DONE;
            end else if (wdog == WD_LAST) begin
                done_tmo   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_id         <= ID_W'(NUM_REQ - 1);
            cur_id          <= '0;
            core_plain_text <= '0;
            core_key        <= '0;
            seen_low        <= 1'b0;
            wdog            <= '0;
            rsp_id          <= '0;
            rsp_cipher_text <= '0;
            rsp_err         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            if (state == IDLE && state_next == LOAD) begin
                core_plain_text <= req_plain_text[grant_id];
                core_key        <= req_key[grant_id];
                cur_id          <= grant_id;
            end
            if (state == LOAD) begin
                last_id  <= cur_id;
                seen_low <= 1'b0;
                wdog     <= '0;
            end
            if (state == BUSY) begin
                if (!core_ready)     seen_low <= 1'b1;
                if (wdog != WD_LAST) wdog     <= wdog + 1'b1;
            end
            if (done_ok || done_tmo) begin
                rsp_id          <= cur_id;
                rsp_cipher_text <= done_ok ? core_cipher_text : '0;
                rsp_err         <= done_tmo;
            end
        end
    end

endmodule

// File: tb/tb_aes_encrypt_sched.sv
// Directed bench for aes_encrypt_sched with a behavioural 10-cycle AES core stand-in.
module tb_aes_encrypt_sched;
    import aes_ctrl_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;
    localparam int ID_W    = 2;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                                clk = 1'b0;
    logic                                reset;
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0][127:0]           req_plain_text;
    logic [NUM_REQ-1:0][127:0]           req_key;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [127:0]                        core_plain_text;
    logic [127:0]                        core_key;
    logic                                core_new_en;
    logic                                core_ready;
    logic [127:0]                        core_cipher_text;
    logic                                rsp_valid;
    logic                                rsp_ready;
    logic [ID_W-1:0]                     rsp_id;
    logic [127:0]                        rsp_cipher_text;
    logic                                rsp_err;
    logic                                busy;

    aes_encrypt_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_plain_text   (req_plain_text),
        .req_key          (req_key),
        .req_ready        (req_ready),
        .core_plain_text  (core_plain_text),
        .core_key         (core_key),
        .core_new_en      (core_new_en),
        .core_ready       (core_ready),
        .core_cipher_text (core_cipher_text),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_cipher_text  (rsp_cipher_text),
        .rsp_err          (rsp_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in: FIPS-197 vector is answered exactly, anything else with pt^key.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ key;
    endfunction

    bit           hung      = 1'b0;
    bit           force_low = 1'b0;
    logic         model_ready = 1'b1;
    int           model_cnt   = 0;
    logic [127:0] model_ct    = '0;

    always @(posedge clk) begin
        if (core_new_en && !hung) begin
            model_cnt   <= 10;
            model_ready <= 1'b0;
            model_ct    <= core_fn(core_plain_text, core_key);
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) model_ready <= 1'b1;
        end
    end

    assign core_ready       = hung ? 1'b1 : (force_low ? 1'b0 : model_ready);
    assign core_cipher_text = model_ct;

    typedef struct {
        int           id;
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs[4];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic wait_grant(output logic [NUM_REQ-1:0] g, output int t);
        bit ok;
        ok = 1'b0;
        g  = '0;
        t  = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                g  = req_ready;
                t  = cyc;
            end
        end
        check("grant_seen", 128'(ok), 128'd1);
    endtask

    task automatic wait_rsp(output int t);
        bit ok;
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
        check("rsp_seen", 128'(ok), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0] g;
        int                 t, t2, t_load, t_rel;
        logic [127:0]       hold_ct;
        int                 order[5];

        vecs[0] = '{2, FIPS_PT, FIPS_KEY, FIPS_CT};
        vecs[1] = '{0, {4{32'hDEADBEEF}}, {4{32'h0F0F0F0F}}, {4{32'hD1A2B1E0}}};
        vecs[2] = '{3, {128{1'b1}}, 128'h0123456789abcdef0123456789abcdef,
                    128'hfedcba9876543210fedcba9876543210};
        vecs[3] = '{1, 128'h80000000_00000000_00000000_00000001,
                    128'h00000000_00000000_ffffffff_ffffffff,
                    128'h80000000_00000000_ffffffff_fffffffe};
        order = '{0, 1, 2, 3, 0};

        reset          = 1'b1;
        req_valid      = '0;
        req_plain_text = '0;
        req_key        = '0;
        rsp_ready      = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        @(negedge clk);
        check("rst_busy",      128'(busy),        128'd0);
        check("rst_req_ready", 128'(req_ready),   128'd0);
        check("rst_new_en",    128'(core_new_en), 128'd0);
        check("rst_rsp_valid", 128'(rsp_valid),   128'd0);
        check("rst_rsp_err",   128'(rsp_err),     128'd0);
        check("rst_rsp_id",    128'(rsp_id),      128'd0);
        check("rst_rsp_ct",    rsp_cipher_text,   128'd0);
        check("rst_core_pt",   core_plain_text,   128'd0);
        check("rst_core_key",  core_key,          128'd0);

        for (int i = 0; i < NUM_REQ; i++) begin
            req_plain_text[vecs[i].id] = vecs[i].pt;
            req_key[vecs[i].id]        = vecs[i].key;
        end

        // Table: one requester at a time, nominal core, rsp_ready already high.
        for (int i = 0; i < 4; i++) begin
            tick();
            req_valid              = '0;
            req_valid[vecs[i].id]  = 1'b1;
            wait_grant(g, t);
            check($sformatf("v%0d_grant", i), 128'(g), 128'(onehot(vecs[i].id)));
            tick();
            req_valid[vecs[i].id] = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_new_en", i),  128'(core_new_en), 128'd1);
            check($sformatf("v%0d_core_pt", i), core_plain_text,   vecs[i].pt);
            check($sformatf("v%0d_core_key", i), core_key,         vecs[i].key);
            wait_rsp(t2);
            check($sformatf("v%0d_latency", i), 128'(t2 - t),   128'd13);
            check($sformatf("v%0d_rsp_id", i),  128'(rsp_id),   128'(vecs[i].id));
            check($sformatf("v%0d_rsp_ct", i),  rsp_cipher_text, vecs[i].ct);
            check($sformatf("v%0d_rsp_err", i), 128'(rsp_err),  128'd0);
            check($sformatf("v%0d_key_hold", i), core_key,      vecs[i].key);
            @(negedge clk);
            check($sformatf("v%0d_idle_valid", i), 128'(rsp_valid), 128'd0);
            check($sformatf("v%0d_idle_busy", i),  128'(busy),      128'd0);
        end

        // Fairness: fresh reset, all requesters valid, expect 0,1,2,3,0.
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, t);
            check($sformatf("rr%0d_grant", i), 128'(g), 128'(onehot(order[i])));
            check($sformatf("rr%0d_onehot", i), 128'($countones(g)), 128'd1);
            @(negedge clk);
            check($sformatf("rr%0d_pulse", i), 128'(req_ready), 128'd0);
        end
        tick();
        req_valid = '0;
        wait_rsp(t2);
        check("rr_last_id", 128'(rsp_id), 128'd0);

        // Back-pressure: response held for 20 cycles while requester 3 waits.
        tick();
        rsp_ready    = 1'b0;
        req_valid[1] = 1'b1;
        wait_grant(g, t);
        check("bp_grant", 128'(g), 128'(onehot(1)));
        tick();
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1;
        wait_rsp(t2);
        check("bp_rsp_id", 128'(rsp_id), 128'd1);
        check("bp_rsp_ct", rsp_cipher_text, vecs[3].ct);
        hold_ct = rsp_cipher_text;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", i),  128'(rsp_valid),  128'd1);
            check($sformatf("bp%0d_id", i),     128'(rsp_id),     128'd1);
            check($sformatf("bp%0d_ct", i),     rsp_cipher_text,  hold_ct);
            check($sformatf("bp%0d_req_rdy", i), 128'(req_ready), 128'd0);
            check($sformatf("bp%0d_new_en", i), 128'(core_new_en), 128'd0);
        end
        tick();
        rsp_ready = 1'b1;
        t_rel     = cyc;
        @(negedge clk);
        check("bp_release_valid",    128'(rsp_valid), 128'd1);
        check("bp_release_no_grant", 128'(req_ready), 128'd0);
        wait_grant(g, t);
        check("bp_next_grant", 128'(g),       128'(onehot(3)));
        check("bp_next_time",  128'(t - t_rel), 128'd1);
        tick();
        req_valid[3] = 1'b0;
        wait_rsp(t2);
        check("bp_next_id", 128'(rsp_id),   128'd3);
        check("bp_next_ct", rsp_cipher_text, vecs[2].ct);

        // Hung core: core_ready never drops, watchdog response.
        tick();
        hung         = 1'b1;
        req_valid[0] = 1'b1;
        wait_grant(g, t);
        check("hung_grant", 128'(g), 128'(onehot(0)));
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("hung_new_en", 128'(core_new_en), 128'd1);
        t_load = cyc;
        wait_rsp(t2);
        check("hung_delay", 128'(t2 - t_load), 128'(TIMEOUT + 1));
        check("hung_err",   128'(rsp_err),     128'd1);
        check("hung_ct",    rsp_cipher_text,   128'd0);
        check("hung_id",    128'(rsp_id),      128'd0);
        tick();
        hung = 1'b0;

        // Reset while BUSY, core held not-ready afterwards.
        req_valid[2] = 1'b1;
        wait_grant(g, t);
        check("rb_grant", 128'(g), 128'(onehot(2)));
        tick();
        req_valid[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rb_busy%0d", i), 128'(busy), 128'd1);
        end
        tick();
        reset     = 1'b1;
        force_low = 1'b1;
        req_valid = '1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rb_busy",      128'(busy),        128'd0);
        check("rb_req_ready", 128'(req_ready),   128'd0);
        check("rb_new_en",    128'(core_new_en), 128'd0);
        check("rb_rsp_valid", 128'(rsp_valid),   128'd0);
        check("rb_rsp_err",   128'(rsp_err),     128'd0);
        check("rb_rsp_id",    128'(rsp_id),      128'd0);
        check("rb_rsp_ct",    rsp_cipher_text,   128'd0);
        check("rb_core_pt",   core_plain_text,   128'd0);
        check("rb_core_key",  core_key,          128'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("rb_hold%0d", i), 128'(req_ready), 128'd0);
        end
        tick();
        force_low = 1'b0;
        @(negedge clk);
        check("rb_first_grant", 128'(req_ready), 128'(onehot(0)));
        t = cyc;
        tick();
        req_valid = '0;
        wait_rsp(t2);
        check("rb_latency", 128'(t2 - t),   128'd13);
        check("rb_rsp_id",  128'(rsp_id),   128'd0);
        check("rb_rsp_ct2", rsp_cipher_text, vecs[1].ct);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_sched.md
# aes_encrypt_sched

Round-robin scheduler that shares one AES-128 encryption core between `NUM_REQ` requesters. It takes a plaintext/key pair from the next requester in turn and sequences one encryption on the core with a single-cycle start pulse. It holds the key stable for the key-expansion path while the core runs, then returns the ciphertext tagged with the requester ID. It sits between client blocks and the core's start/ready/data ports, and includes a watchdog against a hung core.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `TIMEOUT`, 16 — max cycles in BUSY before an error response.
- All ports use one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid; held until its `req_ready`.
- `req_plain_text`  in  NUM_REQ×128  per-requester plaintext (packed array).
- `req_key`  in  NUM_REQ×128  per-requester cipher key.
- `req_ready`  out  NUM_REQ  one-hot grant/accept pulse.
- `core_plain_text`  out  128  plaintext to core.
- `core_key`  out  128  key to core and key expansion; stable from LOAD to the end of BUSY.
- `core_new_en`  out  1  one-cycle start pulse.
- `core_ready`  in  1  core idle flag (high = idle).
- `core_cipher_text`  in  128  core result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_id`  out  $clog2(NUM_REQ)  requester that owns the response.
- `rsp_cipher_text`  out  128  ciphertext; 0 on error.
- `rsp_err`  out  1  watchdog timeout flag.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE → LOAD → BUSY → DONE → IDLE.
- **IDLE**
  - Grant when `|req_valid && core_ready`.
  - Winner is the first valid requester at or after `last_id+1`, wrapping modulo NUM_REQ.
  - `req_ready[winner]` is 1 this cycle; pt, key and id are registered.
  - Next state is LOAD.
  - If no request is valid, or `core_ready`=0, stay in IDLE with `req_ready`=0.
- **LOAD**
  - `core_new_en`=1 for exactly this cycle, with registered pt/key on the core ports.
  - `last_id` ← id.
  - Next state is BUSY. Clear `seen_low` and `wdog`.
- **BUSY**
  - `seen_low` sets when `core_ready`=0 is sampled.
  - When `seen_low && core_ready`: capture `core_cipher_text`, set `rsp_err`=0, go to DONE.
  - `wdog` increments each BUSY cycle. At `wdog==TIMEOUT-1` without completion: go to DONE with `rsp_err`=1 and `rsp_cipher_text`=0.
- **DONE**
  - `rsp_valid`=1. `rsp_id`, `rsp_cipher_text` and `rsp_err` are held.
  - On `rsp_valid && rsp_ready`, go to IDLE. No new grant happens in that same cycle.
- `last_id` resets to NUM_REQ-1, so requester 0 has first priority after reset.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0…
- A requester deasserting valid before its grant is simply skipped.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready`, `core_new_en`, `rsp_valid`, `rsp_err` and `busy` are 0.
  - `rsp_id`, `rsp_cipher_text`, `core_plain_text` and `core_key` are 0.
  - `last_id` is NUM_REQ-1.
- Accept at cycle T. `core_new_en` is high at T+1.
- Nominal core: `core_ready` is low T+2..T+11, high at T+12. Capture at T+12; `rsp_valid` rises at T+13.
- Latency from accept to `rsp_valid` is 13 cycles, plus any extra core cycles.
- `rsp_ready` already high when `rsp_valid` rises: the response completes in 1 cycle. IDLE follows, and the earliest next accept is T+14.
- `core_ready` never drops after LOAD: `seen_low` stays 0, so the watchdog fires. `rsp_valid` rises TIMEOUT+1 cycles after LOAD with `rsp_err`=1.
- Reset mid-operation: the FSM returns to IDLE next cycle and the in-flight result is dropped. Any still-running core encryption is not observed, because IDLE does not grant until `core_ready`=1.
- Simultaneous `reset` and `rsp_ready`: reset wins.
- `rsp_id` wraps from NUM_REQ-1 to 0. No arithmetic overflow: `wdog` is $clog2(TIMEOUT+1) bits and saturates by the state exit.

## Structure
- Package `aes_ctrl_pkg`:
  - `AES_BLOCK_W`=128.
  - enum `sched_state_t` {IDLE, LOAD, BUSY, DONE}.
  - `DEF_TIMEOUT`=16.
- Sub-module `aes_rr_arbiter` (parameter NUM_REQ):
  - Combinational inputs: `req_valid`, `last_id`. Outputs: one-hot `grant` and `grant_id`.
  - Instantiated once. All state is held in the scheduler.

## Test plan
- Single request, FIPS-197 vector:
  - Stimulus: requester 2 sends pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, with a behavioural core model.
  - Response: `rsp_id`=2, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_valid` at T+13.
- All four requesters valid continuously: grants in order 0,1,2,3,0. Each `req_ready` is a one-cycle pulse; never two bits set.
- Back-pressure: hold `rsp_ready`=0 for 20 cycles. `rsp_*` stays stable, no new `req_ready` is issued, and `core_new_en` stays 0.
- Hung core (`core_ready` tied 1): `rsp_err`=1, `rsp_cipher_text`=0, and `rsp_valid` rises TIMEOUT+1 cycles after LOAD.
- `reset` asserted in BUSY:
  - Next cycle: IDLE with all outputs at reset values.
  - With `core_ready` held low by the model, no grant occurs until it returns high. The first grant then goes to requester 0.
